alu_exec_seq: RTL and testbench

//  Next-generation ALU control: decodes op_alu/funct into the 4-bit operation code and also executes
//  the operation on DATA_W-bit operands. Adds the R-type shifts (SLL/SRL/SRA/SLLV/SRLV/SRAV) as an

---
 rtl/alu_exec_seq_if.sv | 40 ++++
 rtl/alu_exec_seq.sv | 212 +++++++++++++++++++++
 tb/tb_alu_exec_seq.sv | 291 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_exec_seq_if.sv
// Request/result bundle for alu_exec_seq: decode-side request channel and writeback-side result channel.
// The ovf member exists only when ALU_OVF_TRAP_EN is defined.
interface alu_exec_seq_if #(
  parameter int DATA_W = 32
);
  localparam int AMT_W = $clog2(DATA_W);

  logic              in_valid;
  logic              in_ready;
  logic [3:0]        op_alu;
  logic [5:0]        funct;
  logic [DATA_W-1:0] src_a;
  logic [DATA_W-1:0] src_b;
  logic [AMT_W-1:0]  shamt;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] result;
  logic [3:0]        operation;
  logic              zero;
  logic              busy;
`ifdef ALU_OVF_TRAP_EN
  logic              ovf;
`endif

  modport master (
`ifdef ALU_OVF_TRAP_EN
    input  ovf,
`endif
    output in_valid, op_alu, funct, src_a, src_b, shamt, out_ready,
    input  in_ready, out_valid, result, operation, zero, busy
  );

  modport slave (
`ifdef ALU_OVF_TRAP_EN
    output ovf,
`endif
    input  in_valid, op_alu, funct, src_a, src_b, shamt, out_ready,
    output in_ready, out_valid, result, operation, zero, busy
  );
endinterface

// File: rtl/alu_exec_seq.sv
// ALU control decode plus execute, with an iterative shifter (up to SHIFT_STEP bits per cycle).
// Optional feature macro ALU_OVF_TRAP_EN: adds registered signed-overflow flag ovf for ADD/SUB.
module alu_exec_seq #(
  parameter int DATA_W     = 32,
  parameter int SHIFT_STEP = 1
) (
  input logic           clk,
  input logic           reset_n,
  alu_exec_seq_if.slave bus
);
  localparam int AMT_W = $clog2(DATA_W);
  localparam logic [AMT_W:0] STEP_L = (AMT_W+1)'(SHIFT_STEP);

  localparam logic [3:0] OP_AND  = 4'b0000, OP_OR   = 4'b0001, OP_ADD  = 4'b0010,
                         OP_ADDU = 4'b0011, OP_MOVN = 4'b0100, OP_SUB  = 4'b0110,
                         OP_SUBU = 4'b0111, OP_GEZ  = 4'b1000, OP_SLT  = 4'b1001,
                         OP_SLL  = 4'b1010, OP_SRL  = 4'b1011, OP_NOR  = 4'b1100,
                         OP_XOR  = 4'b1101, OP_SRA  = 4'b1110, OP_LUI  = 4'b1111;

  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, DONE = 2'd2} state_t;

  function automatic logic [3:0] decode_op(input logic [3:0] op_alu, input logic [5:0] funct);
    logic [3:0] code;
    code = OP_ADD;
    case (op_alu)
      4'b0000: code = OP_ADD;
      4'b0001: code = OP_SUB;
      4'b0010: code = OP_AND;
      4'b0011: code = OP_NOR;
      4'b0100: code = OP_OR;
      4'b0101: code = OP_XOR;
      4'b0111: code = OP_GEZ;
      4'b1000: code = OP_ADDU;
      4'b1001: code = OP_LUI;
      4'b1010: code = OP_SLT;
      4'b0110: begin
        case (funct)
          6'b100000: code = OP_ADD;
          6'b100001: code = OP_ADDU;
          6'b100100: code = OP_AND;
          6'b001011: code = OP_MOVN;
          6'b100111: code = OP_NOR;
          6'b100101: code = OP_OR;
          6'b101010: code = OP_SLT;
          6'b100010: code = OP_SUB;
          6'b100011: code = OP_SUBU;
          6'b100110: code = OP_XOR;
          6'b000000, 6'b000100: code = OP_SLL;
          6'b000010, 6'b000110: code = OP_SRL;
          6'b000011, 6'b000111: code = OP_SRA;
          default: code = OP_ADD;
        endcase
      end
      default: code = OP_ADD;
    endcase
    return code;
  endfunction

  // Shift codes return src_b unchanged: that is the zero-amount result and the shifter seed.
  function automatic logic [DATA_W-1:0] alu_calc(input logic [3:0] code,
                                                  input logic [DATA_W-1:0] a,
                                                  input logic [DATA_W-1:0] b);
    logic signed [DATA_W-1:0] sa;
    logic signed [DATA_W-1:0] sb;
    logic [DATA_W-1:0] r;
    sa = a;
    sb = b;
    r  = '0;
    case (code)
      OP_ADD, OP_ADDU:        r = a + b;
      OP_SUB, OP_SUBU:        r = a - b;
      OP_AND:                 r = a & b;
      OP_OR:                  r = a | b;
      OP_XOR:                 r = a ^ b;
      OP_NOR:                 r = ~(a | b);
      OP_SLT:                 r = {{(DATA_W-1){1'b0}}, (sa < sb)};
      OP_GEZ:                 r = {{(DATA_W-1){1'b0}}, ~a[DATA_W-1]};
      OP_LUI:                 r = b << (DATA_W/2);
      OP_MOVN:                r = a;
      OP_SLL, OP_SRL, OP_SRA: r = b;
      default:                r = '0;
    endcase
    return r;
  endfunction

  function automatic logic [DATA_W-1:0] shift_by(input logic [3:0] code,
                                                  input logic [DATA_W-1:0] v,
                                                  input logic [AMT_W-1:0] s);
    logic signed [DATA_W-1:0] sv;
    logic [DATA_W-1:0] r;
    sv = v;
    case (code)
      OP_SLL:  r = v << s;
      OP_SRL:  r = v >> s;
      OP_SRA:  r = sv >>> s;
      default: r = v;
    endcase
    return r;
  endfunction

`ifdef ALU_OVF_TRAP_EN
  function automatic logic ovf_calc(input logic [3:0] code, input logic [DATA_W-1:0] a,
                                    input logic [DATA_W-1:0] b);
    logic [DATA_W-1:0] sum;
    logic [DATA_W-1:0] dif;
    logic o;
    sum = a + b;
    dif = a - b;
    o   = 1'b0;
    if (code == OP_ADD)
      o = (a[DATA_W-1] == b[DATA_W-1]) && (sum[DATA_W-1] != a[DATA_W-1]);
    else if (code == OP_SUB)
      o = (a[DATA_W-1] != b[DATA_W-1]) && (dif[DATA_W-1] != a[DATA_W-1]);
    return o;
  endfunction
`endif

  state_t            state, state_nx;
  logic              in_ready, out_valid, busy, accept;
  logic [3:0]        req_code;
  logic [AMT_W-1:0]  req_amt;
  logic              req_to_shift;
  logic [DATA_W-1:0] req_res;
  logic [DATA_W-1:0] acc_p0, acc_nx;
  logic [AMT_W-1:0]  cnt_p0, step_amt;
  logic              last_step;
  logic [DATA_W-1:0] result_p1;
  logic [3:0]        operation_p1;
  logic              zero_p1;
`ifdef ALU_OVF_TRAP_EN
  logic              ovf_p1;
`endif

  assign accept       = bus.in_valid && in_ready;
  assign req_code     = decode_op(bus.op_alu, bus.funct);
  assign req_amt      = bus.funct[2] ? bus.src_a[AMT_W-1:0] : bus.shamt;
  assign req_to_shift = (req_code == OP_SLL || req_code == OP_SRL || req_code == OP_SRA)
                        && (req_amt != '0);
  assign req_res      = alu_calc(req_code, bus.src_a, bus.src_b);
  // cnt never exceeds DATA_W-1, so the truncated STEP_L is only used when it fits.
  assign last_step    = ({1'b0, cnt_p0} <= STEP_L);
  assign step_amt     = last_step ? cnt_p0 : STEP_L[AMT_W-1:0];
  assign acc_nx       = shift_by(operation_p1, acc_p0, step_amt);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE, DONE: begin
        if (accept)                                state_nx = req_to_shift ? SHIFT : DONE;
        else if (state == DONE && bus.out_ready)   state_nx = IDLE;
      end
      SHIFT:   if (last_step) state_nx = DONE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == IDLE) || (state == DONE && bus.out_ready);
    out_valid = (state == DONE);
    busy      = (state == SHIFT);
  end

  // Stage p0: shifter working registers (data only, no reset needed).
  always_ff @(posedge clk) begin
    if (accept) begin
      acc_p0 <= bus.src_b;
      cnt_p0 <= req_amt;
    end else if (state == SHIFT) begin
      acc_p0 <= acc_nx;
      cnt_p0 <= cnt_p0 - step_amt;
    end
  end

  // Stage p1: architecturally visible result registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      result_p1    <= '0;
      operation_p1 <= 4'hF;
      zero_p1      <= 1'b0;
`ifdef ALU_OVF_TRAP_EN
      ovf_p1       <= 1'b0;
`endif
    end else if (accept) begin
      operation_p1 <= req_code;
`ifdef ALU_OVF_TRAP_EN
      ovf_p1       <= ovf_calc(req_code, bus.src_a, bus.src_b);
`endif
      if (!req_to_shift) begin
        result_p1 <= req_res;
        zero_p1   <= (req_res == '0);
      end
    end else if (state == SHIFT && last_step) begin
      result_p1 <= acc_nx;
      zero_p1   <= (acc_nx == '0);
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.busy      = busy;
  assign bus.result    = result_p1;
  assign bus.operation = operation_p1;
  assign bus.zero      = zero_p1;
`ifdef ALU_OVF_TRAP_EN
  assign bus.ovf       = ovf_p1;
`endif
endmodule

// File: tb/tb_alu_exec_seq.sv
// Randomized self-checking bench for alu_exec_seq against a direct arithmetic reference model.
// Checks ovf as well when ALU_OVF_TRAP_EN is defined.
module tb_alu_exec_seq;
  localparam int DATA_W = 32;
  localparam int AMT_W  = 5;
  localparam int STEP   = 3;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  alu_exec_seq_if #(.DATA_W(DATA_W)) bus ();
  alu_exec_seq #(.DATA_W(DATA_W), .SHIFT_STEP(STEP)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));

  int vectors = 0;
  int errors  = 0;

  logic [5:0] funct_list [16] = '{6'b100000, 6'b100001, 6'b100100, 6'b001011, 6'b100111,
                                  6'b100101, 6'b101010, 6'b100010, 6'b100011, 6'b100110,
                                  6'b000000, 6'b000100, 6'b000010, 6'b000110, 6'b000011,
                                  6'b000111};

  function automatic logic [3:0] m_code(input logic [3:0] op, input logic [5:0] f);
    case (op)
      4'd0: return 4'h2;  4'd1: return 4'h6;  4'd2: return 4'h0;  4'd3: return 4'hC;
      4'd4: return 4'h1;  4'd5: return 4'hD;  4'd7: return 4'h8;  4'd8: return 4'h3;
      4'd9: return 4'hF;  4'd10: return 4'h9;
      4'd6: begin
        case (f)
          6'b100000: return 4'h2;  6'b100001: return 4'h3;  6'b100100: return 4'h0;
          6'b001011: return 4'h4;  6'b100111: return 4'hC;  6'b100101: return 4'h1;
          6'b101010: return 4'h9;  6'b100010: return 4'h6;  6'b100011: return 4'h7;
          6'b100110: return 4'hD;
          6'b000000, 6'b000100: return 4'hA;
          6'b000010, 6'b000110: return 4'hB;
          6'b000011, 6'b000111: return 4'hE;
          default: return 4'h2;
        endcase
      end
      default: return 4'h2;
    endcase
  endfunction

  function automatic bit m_is_shift(input logic [3:0] c);
    return (c == 4'hA || c == 4'hB || c == 4'hE);
  endfunction

  function automatic int m_amt(input logic [5:0] f, input logic [31:0] a, input logic [4:0] sh);
    return f[2] ? int'(a % 32) : int'(sh);
  endfunction

  function automatic logic [31:0] m_res(input logic [3:0] c, input logic [31:0] a,
                                        input logic [31:0] b, input int amt);
    longint sa, sb;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (c)
      4'h2, 4'h3: return a + b;
      4'h6, 4'h7: return a - b;
      4'h0: return a & b;
      4'h1: return a | b;
      4'hD: return a ^ b;
      4'hC: return ~(a | b);
      4'h9: return (sa < sb) ? 32'd1 : 32'd0;
      4'h8: return (sa >= 0) ? 32'd1 : 32'd0;
      4'hF: return b * 32'h1_0000;
      4'h4: return a;
      4'hA: return b << amt;
      4'hB: return b >> amt;
      4'hE: return 32'((sb / (longint'(1) << amt)) - (((sb % (longint'(1) << amt)) < 0) ? 1 : 0));
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic m_ovf(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
    longint r;
    r = 0;
    if (c == 4'h2) r = longint'($signed(a)) + longint'($signed(b));
    else if (c == 4'h6) r = longint'($signed(a)) - longint'($signed(b));
    return (r > 64'sd2147483647) || (r < -64'sd2147483648);
  endfunction

  function automatic int m_lat(input logic [3:0] c, input int amt);
    if (m_is_shift(c) && amt != 0) return (amt + STEP - 1) / STEP + 1;
    return 1;
  endfunction

  // Drives one request with out_ready high and reports what the DUT produced.
  task automatic issue(input logic [3:0] op, input logic [5:0] f, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] sh,
                       output logic rdy, output int lat, output int nbusy,
                       output logic [31:0] res, output logic [3:0] opc, output logic z,
                       output logic ov);
    @(negedge clk);
    bus.op_alu = op; bus.funct = f; bus.src_a = a; bus.src_b = b; bus.shamt = sh;
    bus.in_valid = 1'b1; bus.out_ready = 1'b1;
    rdy = bus.in_ready;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    lat = 1; nbusy = 0;
    while (!bus.out_valid && lat < 200) begin
      if (bus.busy) nbusy++;
      @(negedge clk);
      lat++;
    end
    res = bus.result; opc = bus.operation; z = bus.zero;
`ifdef ALU_OVF_TRAP_EN
    ov = bus.ovf;
`else
    ov = 1'b0;
`endif
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    vectors++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); end
    vectors++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
    vectors++; if (bus.result !== 32'h0) begin errors++; $display("FAIL reset_result: got %h want 0", bus.result); end
    vectors++; if (bus.operation !== 4'hF) begin errors++; $display("FAIL reset_operation: got %h want f", bus.operation); end
    vectors++; if (bus.zero !== 1'b0) begin errors++; $display("FAIL reset_zero: got %b want 0", bus.zero); end
    vectors++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", bus.in_ready); end
    reset_n = 1'b1;
  endtask

  task automatic test_examples();
    logic rdy, z, ov; int lat, nb; logic [31:0] res; logic [3:0] opc;
    issue(4'b0000, 6'h0, 32'd5, 32'd7, 5'd0, rdy, lat, nb, res, opc, z, ov);
    vectors++; if (lat != 1 || res !== 32'd12 || opc !== 4'h2 || z !== 1'b0) begin errors++;
      $display("FAIL ex_add: got lat=%0d res=%h op=%h z=%b want lat=1 res=0000000c op=2 z=0", lat, res, opc, z); end
    issue(4'b0110, 6'b000011, 32'h0, 32'h8000_0000, 5'd4, rdy, lat, nb, res, opc, z, ov);
    vectors++; if (lat != 3 || nb != 2 || res !== 32'hF800_0000 || opc !== 4'hE) begin errors++;
      $display("FAIL ex_sra: got lat=%0d busy=%0d res=%h op=%h want lat=3 busy=2 res=f8000000 op=e", lat, nb, res, opc); end
    issue(4'b0110, 6'b000110, 32'h23, 32'hF0, 5'd0, rdy, lat, nb, res, opc, z, ov);
    vectors++; if (lat != 2 || res !== 32'h1E || opc !== 4'hB) begin errors++;
      $display("FAIL ex_srlv: got lat=%0d res=%h op=%h want lat=2 res=0000001e op=b", lat, res, opc); end
    issue(4'b1010, 6'h0, 32'hFFFF_FFFF, 32'h0, 5'd0, rdy, lat, nb, res, opc, z, ov);
    vectors++; if (res !== 32'd1 || opc !== 4'h9) begin errors++;
      $display("FAIL ex_slt: got res=%h op=%h want res=00000001 op=9", res, opc); end
    issue(4'b1001, 6'h0, 32'h0, 32'h1234, 5'd0, rdy, lat, nb, res, opc, z, ov);
    vectors++; if (res !== 32'h1234_0000 || opc !== 4'hF) begin errors++;
      $display("FAIL ex_lui: got res=%h op=%h want res=12340000 op=f", res, opc); end
    issue(4'b1111, 6'h0, 32'd3, 32'd4, 5'd0, rdy, lat, nb, res, opc, z, ov);
    vectors++; if (res !== 32'd7 || opc !== 4'h2) begin errors++;
      $display("FAIL ex_undef_op: got res=%h op=%h want res=00000007 op=2", res, opc); end
    issue(4'b0001, 6'h0, 32'd9, 32'd9, 5'd0, rdy, lat, nb, res, opc, z, ov);
    vectors++; if (res !== 32'd0 || z !== 1'b1 || opc !== 4'h6) begin errors++;
      $display("FAIL ex_sub_zero: got res=%h z=%b op=%h want res=0 z=1 op=6", res, z, opc); end
    issue(4'b0110, 6'b000000, 32'h0, 32'hABCD, 5'd0, rdy, lat, nb, res, opc, z, ov);
    vectors++; if (lat != 1 || res !== 32'hABCD || opc !== 4'hA) begin errors++;
      $display("FAIL ex_sll0: got lat=%0d res=%h op=%h want lat=1 res=0000abcd op=a", lat, res, opc); end
  endtask

  task automatic test_random_ops(input int n, input bit shifts_only);
    logic rdy, z, ov; int lat, nb, amt; logic [31:0] res, a, b, er; logic [3:0] opc, op, ec;
    logic [5:0] f; logic [4:0] sh;
    for (int i = 0; i < n; i++) begin
      a  = $urandom; b = $urandom; sh = 5'($urandom);
      if ($urandom_range(0, 3) == 0) b = 32'h8000_0000 | 32'($urandom_range(0, 3));
      if ($urandom_range(0, 4) == 0) a = b;
      if (shifts_only) begin
        op = 4'd6; f = funct_list[$urandom_range(10, 15)];
      end else begin
        op = 4'($urandom_range(0, 15));
        f  = ($urandom_range(0, 3) == 0) ? 6'($urandom) : funct_list[$urandom_range(0, 15)];
      end
      ec  = m_code(op, f);
      amt = m_amt(f, a, sh);
      er  = m_res(ec, a, b, amt);
      issue(op, f, a, b, sh, rdy, lat, nb, res, opc, z, ov);
      vectors++; if (rdy !== 1'b1) begin errors++; $display("FAIL rnd_in_ready[%0d]: got %b want 1", i, rdy); end
      vectors++; if (lat != m_lat(ec, amt) || nb != m_lat(ec, amt) - 1) begin errors++;
        $display("FAIL rnd_latency[%0d]: got lat=%0d busy=%0d want lat=%0d op_alu=%h funct=%b amt=%0d", i, lat, nb, m_lat(ec, amt), op, f, amt); end
      vectors++; if (res !== er || opc !== ec || z !== (er == 32'h0)) begin errors++;
        $display("FAIL rnd_result[%0d]: got res=%h op=%h z=%b want res=%h op=%h z=%b (a=%h b=%h amt=%0d)", i, res, opc, z, er, ec, (er == 32'h0), a, b, amt); end
`ifdef ALU_OVF_TRAP_EN
      vectors++; if (ov !== m_ovf(ec, a, b)) begin errors++;
        $display("FAIL rnd_ovf[%0d]: got %b want %b (op=%h a=%h b=%h)", i, ov, m_ovf(ec, a, b), ec, a, b); end
`endif
    end
  endtask

  task automatic test_hold_and_backpressure();
    int cyc; logic [31:0] a2, b2, er;
    a2 = $urandom; b2 = $urandom;
    er = m_res(4'hB, 32'h0, 32'hFFFF_0000, 7);
    @(negedge clk);
    bus.op_alu = 4'd6; bus.funct = 6'b000010; bus.src_a = 32'h0; bus.src_b = 32'hFFFF_0000;
    bus.shamt = 5'd7; bus.in_valid = 1'b1; bus.out_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    bus.op_alu = 4'd0; bus.funct = 6'h0; bus.src_a = a2; bus.src_b = b2;
    cyc = 1;
    while (!bus.out_valid && cyc < 200) begin
      vectors++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL hold_in_ready_shift: got %b want 0 at cycle %0d", bus.in_ready, cyc); end
      @(negedge clk); cyc++;
    end
    vectors++; if (cyc != m_lat(4'hB, 7) || bus.result !== er) begin errors++;
      $display("FAIL hold_shift_result: got lat=%0d res=%h want lat=%0d res=%h", cyc, bus.result, m_lat(4'hB, 7), er); end
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      vectors++; if (bus.out_valid !== 1'b1 || bus.result !== er || bus.operation !== 4'hB || bus.in_ready !== 1'b0) begin errors++;
        $display("FAIL backpressure[%0d]: got vld=%b res=%h op=%h rdy=%b want vld=1 res=%h op=b rdy=0", k, bus.out_valid, bus.result, bus.operation, bus.in_ready, er); end
    end
    bus.out_ready = 1'b1;
    #1;
    vectors++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL drain_accept_ready: got %b want 1", bus.in_ready); end
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    vectors++; if (bus.out_valid !== 1'b1 || bus.result !== a2 + b2 || bus.operation !== 4'h2) begin errors++;
      $display("FAIL drain_new_add: got vld=%b res=%h op=%h want vld=1 res=%h op=2", bus.out_valid, bus.result, bus.operation, a2 + b2); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_r [20];
    logic [3:0]  exp_c [20];
    logic [3:0]  op; logic [31:0] a, b;
    for (int i = 0; i <= 20; i++) begin
      @(negedge clk);
      if (i > 0) begin
        vectors++; if (bus.out_valid !== 1'b1 || bus.result !== exp_r[i-1] || bus.operation !== exp_c[i-1]) begin errors++;
          $display("FAIL b2b[%0d]: got vld=%b res=%h op=%h want vld=1 res=%h op=%h", i-1, bus.out_valid, bus.result, bus.operation, exp_r[i-1], exp_c[i-1]); end
      end
      if (i < 20) begin
        do op = 4'($urandom_range(0, 15)); while (op == 4'd6);
        a = $urandom; b = $urandom;
        exp_c[i] = m_code(op, 6'h0);
        exp_r[i] = m_res(exp_c[i], a, b, 0);
        bus.op_alu = op; bus.funct = 6'h0; bus.src_a = a; bus.src_b = b; bus.shamt = 5'd0;
        bus.in_valid = 1'b1; bus.out_ready = 1'b1;
        vectors++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL b2b_in_ready[%0d]: got %b want 1", i, bus.in_ready); end
      end else begin
        bus.in_valid = 1'b0;
      end
    end
  endtask

  task automatic test_reset_mid_shift();
    logic rdy, z, ov; int lat, nb; logic [31:0] res; logic [3:0] opc;
    @(negedge clk);
    bus.op_alu = 4'd6; bus.funct = 6'b000000; bus.src_a = 32'h0; bus.src_b = 32'h1;
    bus.shamt = 5'd31; bus.in_valid = 1'b1; bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    @(negedge clk);
    vectors++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL midshift_busy: got %b want 1", bus.busy); end
    reset_n = 1'b0;
    #1;
    vectors++; if (bus.out_valid !== 1'b0 || bus.operation !== 4'hF || bus.busy !== 1'b0 || bus.result !== 32'h0 || bus.in_ready !== 1'b1) begin errors++;
      $display("FAIL midshift_reset: got vld=%b op=%h busy=%b res=%h rdy=%b want vld=0 op=f busy=0 res=0 rdy=1", bus.out_valid, bus.operation, bus.busy, bus.result, bus.in_ready); end
    @(negedge clk);
    reset_n = 1'b1;
    issue(4'b0100, 6'h0, 32'h0F0F_0000, 32'h0000_00F0, 5'd0, rdy, lat, nb, res, opc, z, ov);
    vectors++; if (lat != 1 || res !== 32'h0F0F_00F0 || opc !== 4'h1) begin errors++;
      $display("FAIL post_reset_or: got lat=%0d res=%h op=%h want lat=1 res=0f0f00f0 op=1", lat, res, opc); end
  endtask

`ifdef ALU_OVF_TRAP_EN
  task automatic test_ovf();
    logic rdy, z, ov; int lat, nb; logic [31:0] res; logic [3:0] opc;
    issue(4'b0000, 6'h0, 32'h7FFF_FFFF, 32'd1, 5'd0, rdy, lat, nb, res, opc, z, ov);
    vectors++; if (ov !== 1'b1 || res !== 32'h8000_0000) begin errors++; $display("FAIL ovf_add: got ovf=%b res=%h want ovf=1 res=80000000", ov, res); end
    issue(4'b1000, 6'h0, 32'h7FFF_FFFF, 32'd1, 5'd0, rdy, lat, nb, res, opc, z, ov);
    vectors++; if (ov !== 1'b0 || res !== 32'h8000_0000) begin errors++; $display("FAIL ovf_addu: got ovf=%b res=%h want ovf=0 res=80000000", ov, res); end
    issue(4'b0001, 6'h0, 32'h8000_0000, 32'd1, 5'd0, rdy, lat, nb, res, opc, z, ov);
    vectors++; if (ov !== 1'b1 || res !== 32'h7FFF_FFFF) begin errors++; $display("FAIL ovf_sub: got ovf=%b res=%h want ovf=1 res=7fffffff", ov, res); end
  endtask
`endif

  initial begin
    reset_n = 1'b0;
    bus.in_valid = 1'b0; bus.out_ready = 1'b0; bus.op_alu = 4'h0; bus.funct = 6'h0;
    bus.src_a = '0; bus.src_b = '0; bus.shamt = '0;
    test_reset();
    test_examples();
    test_random_ops(40, 1'b0);
    test_random_ops(30, 1'b1);
    test_hold_and_backpressure();
    test_back_to_back();
    test_reset_mid_shift();
`ifdef ALU_OVF_TRAP_EN
    test_ovf();
`endif
    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
